// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output reorder path: sample layout, bank states and the
// bit-reversal helper used to address the reorder RAM.
package fft_pkg;

    localparam int unsigned CPLX_WIDTH = 32;
    localparam int unsigned REAL_MSB   = CPLX_WIDTH - 1;
    localparam int unsigned REAL_LSB   = CPLX_WIDTH / 2;
    localparam int unsigned IMGN_MSB   = CPLX_WIDTH / 2 - 1;
    localparam int unsigned IMGN_LSB   = 0;
    localparam int unsigned MAX_LOG2N  = 12;

    typedef logic [1:0] bank_state_t;

    localparam bank_state_t BANK_EMPTY    = 2'd0;
    localparam bank_state_t BANK_FILLING  = 2'd1;
    localparam bank_state_t BANK_FULL     = 2'd2;
    localparam bank_state_t BANK_DRAINING = 2'd3;

    // Reverses the low log2n bits of value; bits above log2n come back as zero.
    function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] value,
                                                    input int unsigned log2n);
        logic [MAX_LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < int'(MAX_LOG2N); i++) begin
            if (i < int'(log2n)) begin
                r[i] = value[int'(log2n) - 1 - i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Simple dual-port RAM for the reorder buffer: one write port, one read port with a
// registered output that holds its value while rd_en is low.
module fft_reorder_ram #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Captures FFT frames arriving in bit-reversed order and replays them in natural order.
// Define FFT_REORDER_PINGPONG_EN for two banks (streaming); otherwise one bank is used.
module fft_bitrev_reorder #(
    parameter int unsigned CPLX_WIDTH = 32,
    parameter int unsigned LOG2N      = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CPLX_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CPLX_WIDTH-1:0] out_data,
    output logic [LOG2N-1:0]      out_index,
    output logic                  out_last
);

    import fft_pkg::*;

    localparam int unsigned N = 1 << LOG2N;
    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

`ifdef FFT_REORDER_PINGPONG_EN
    localparam int unsigned NUM_BANKS = 2;
    localparam logic        PINGPONG  = 1'b1;
`else
    localparam int unsigned NUM_BANKS = 1;
    localparam logic        PINGPONG  = 1'b0;
`endif

    localparam int unsigned ADDR_W = $clog2(NUM_BANKS * N);

    bank_state_t bank_q [2];
    bank_state_t bank_d [2];

    logic             wr_bank_q, wr_bank_d;
    logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
    logic             rd_bank_q, rd_bank_d;
    logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;

    // Stage A is the RAM output register; stage S is the skid entry behind it.
    logic             a_valid_q, a_valid_d;
    logic [LOG2N-1:0] a_idx_q, a_idx_d;
    logic             a_last_q, a_last_d;
    logic             a_bank_q, a_bank_d;
    logic                  s_valid_q, s_valid_d;
    logic [CPLX_WIDTH-1:0] s_data_q, s_data_d;
    logic [LOG2N-1:0]      s_idx_q, s_idx_d;
    logic                  s_last_q, s_last_d;
    logic                  s_bank_q, s_bank_d;

    logic [CPLX_WIDTH-1:0] ram_rdata;
    logic [ADDR_W-1:0]     ram_waddr, ram_raddr;
    logic [LOG2N-1:0]      wr_rev;

    bank_state_t           wr_state, rd_state;
    logic                  head_valid, head_last, head_bank;
    logic [CPLX_WIDTH-1:0] head_data;
    logic [LOG2N-1:0]      head_idx;
    logic                  pop, last_pop, wr_ok, wr_en, rd_en;

    assign wr_state   = bank_q[wr_bank_q];
    assign rd_state   = bank_q[rd_bank_q];
    assign head_valid = s_valid_q | a_valid_q;
    assign head_data  = s_valid_q ? s_data_q : ram_rdata;
    assign head_idx   = s_valid_q ? s_idx_q  : a_idx_q;
    assign head_last  = s_valid_q ? s_last_q : a_last_q;
    assign head_bank  = s_valid_q ? s_bank_q : a_bank_q;
    assign pop        = head_valid & out_ready;
    assign last_pop   = pop & head_last;

    // A bank whose final sample leaves this cycle may be refilled in the same cycle.
    assign wr_ok = (wr_state == BANK_EMPTY) || (wr_state == BANK_FILLING) ||
                   ((wr_state == BANK_DRAINING) && last_pop && (head_bank == wr_bank_q));
    assign in_ready = wr_ok & ~rst;
    assign wr_en    = in_valid & in_ready;

    // Read only while addresses remain and the two-entry output path has room.
    assign rd_en = ((rd_state == BANK_FULL) ||
                    ((rd_state == BANK_DRAINING) && (rd_cnt_q != '0))) &&
                   !(a_valid_q && s_valid_q);

    assign wr_rev = LOG2N'(bitrev(MAX_LOG2N'(wr_cnt_q), LOG2N));

`ifdef FFT_REORDER_PINGPONG_EN
    assign ram_waddr = {wr_bank_q, wr_rev};
    assign ram_raddr = {rd_bank_q, rd_cnt_q};
`else
    assign ram_waddr = wr_rev;
    assign ram_raddr = rd_cnt_q;
`endif

    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        wr_bank_d = wr_bank_q;
        rd_cnt_d  = rd_cnt_q;
        rd_bank_d = rd_bank_q;
        a_valid_d = a_valid_q;
        a_idx_d   = a_idx_q;
        a_last_d  = a_last_q;
        a_bank_d  = a_bank_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;
        s_idx_d   = s_idx_q;
        s_last_d  = s_last_q;
        s_bank_d  = s_bank_q;

        if (wr_en) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            if (wr_cnt_q == LAST_IDX) begin
                wr_bank_d = PINGPONG & ~wr_bank_q;
            end
        end

        if (s_valid_q) begin
            if (pop) begin
                s_valid_d = 1'b0;
            end
        end else if (a_valid_q && !pop) begin
            s_valid_d = 1'b1;
            s_data_d  = ram_rdata;
            s_idx_d   = a_idx_q;
            s_last_d  = a_last_q;
            s_bank_d  = a_bank_q;
        end

        if (a_valid_q && !s_valid_q) begin
            a_valid_d = 1'b0;
        end

        if (rd_en) begin
            rd_cnt_d  = rd_cnt_q + 1'b1;
            a_valid_d = 1'b1;
            a_idx_d   = rd_cnt_q;
            a_last_d  = (rd_cnt_q == LAST_IDX);
            a_bank_d  = rd_bank_q;
            if (rd_cnt_q == LAST_IDX) begin
                rd_bank_d = PINGPONG & ~rd_bank_q;
            end
        end
    end

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_d[b] = bank_q[b];
            if (last_pop && (head_bank == 1'(b))) begin
                bank_d[b] = BANK_EMPTY;
            end
            if (rd_en && (rd_bank_q == 1'(b)) && (rd_state == BANK_FULL)) begin
                bank_d[b] = BANK_DRAINING;
            end
            if (wr_en && (wr_bank_q == 1'(b))) begin
                bank_d[b] = (wr_cnt_q == LAST_IDX) ? BANK_FULL : BANK_FILLING;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q[0] <= BANK_EMPTY;
            bank_q[1] <= BANK_EMPTY;
            wr_cnt_q  <= '0;
            wr_bank_q <= 1'b0;
            rd_cnt_q  <= '0;
            rd_bank_q <= 1'b0;
            a_valid_q <= 1'b0;
            a_idx_q   <= '0;
            a_last_q  <= 1'b0;
            a_bank_q  <= 1'b0;
            s_valid_q <= 1'b0;
            s_data_q  <= '0;
            s_idx_q   <= '0;
            s_last_q  <= 1'b0;
            s_bank_q  <= 1'b0;
        end else begin
            bank_q[0] <= bank_d[0];
            bank_q[1] <= bank_d[1];
            wr_cnt_q  <= wr_cnt_d;
            wr_bank_q <= wr_bank_d;
            rd_cnt_q  <= rd_cnt_d;
            rd_bank_q <= rd_bank_d;
            a_valid_q <= a_valid_d;
            a_idx_q   <= a_idx_d;
            a_last_q  <= a_last_d;
            a_bank_q  <= a_bank_d;
            s_valid_q <= s_valid_d;
            s_data_q  <= s_data_d;
            s_idx_q   <= s_idx_d;
            s_last_q  <= s_last_d;
            s_bank_q  <= s_bank_d;
        end
    end

    fft_reorder_ram #(
        .WIDTH  (CPLX_WIDTH),
        .DEPTH  (NUM_BANKS * N),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (ram_waddr),
        .wr_data (in_data),
        .rd_en   (rd_en),
        .rd_addr (ram_raddr),
        .rd_data (ram_rdata)
    );

    // Outputs read as zero when idle so reset leaves a clean bus.
    assign out_valid = head_valid;
    assign out_data  = head_valid ? head_data : '0;
    assign out_index = head_valid ? head_idx : '0;
    assign out_last  = head_valid & head_last;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Self-checking bench for fft_bitrev_reorder (LOG2N=3) against a natural-order frame model.
module tb_fft_bitrev_reorder;

    localparam int LOG2N = 3;
    localparam int N     = 8;
    localparam int W     = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready, out_valid, out_ready, out_last;
    logic [W-1:0]     in_data, out_data;
    logic [LOG2N-1:0] out_index;

    always #5 clk = ~clk;

    fft_bitrev_reorder #(
        .CPLX_WIDTH (W),
        .LOG2N      (LOG2N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last)
    );

    int checks = 0;
    int errors = 0;

    logic [W-1:0] in_q[$];
    bit           rdy_pat[$];
    bit           rand_valid;
    logic [W-1:0] exp_d[$];
    int           exp_i[$];
    logic [W-1:0] od_q[$];
    int           oi_q[$];
    bit           ol_q[$];
    bit           ir_log[$];
    bit           inf_log[$];
    bit           lastfire_log[$];
    int           last_in_cyc, first_ov_cyc, stall_err;
    bit           timed_out;

    function automatic int rev(input int v, input int bits);
        int r = 0;
        for (int i = 0; i < bits; i++) begin
            r = (r << 1) | (v & 1);
            v = v >> 1;
        end
        return r;
    endfunction

    // Arrival position k carries bin rev(k); natural bin j is therefore arrival rev(j).
    task automatic push_frame(input logic [W-1:0] f[N]);
        for (int k = 0; k < N; k++) in_q.push_back(f[k]);
        for (int j = 0; j < N; j++) begin
            exp_d.push_back(f[rev(j, LOG2N)]);
            exp_i.push_back(j);
        end
    endtask

    task automatic clear_model();
        in_q.delete();
        exp_d.delete();
        exp_i.delete();
    endtask

    task automatic run(input int max_cyc, input int out_target);
        int               n = 0;
        bit               held = 0;
        logic [W-1:0]     hd = '0;
        logic [LOG2N-1:0] hi = '0;
        logic             hl = 1'b0;
        od_q.delete(); oi_q.delete(); ol_q.delete();
        ir_log.delete(); inf_log.delete(); lastfire_log.delete();
        stall_err = 0; first_ov_cyc = -1; last_in_cyc = -1; timed_out = 0;
        while (!(in_q.size() == 0 && od_q.size() >= out_target)) begin
            if (n >= max_cyc) begin
                timed_out = 1;
                break;
            end
            @(posedge clk);
            #1;
            in_valid  = (in_q.size() > 0) && (!rand_valid || $urandom_range(3) != 0);
            in_data   = in_valid ? in_q[0] : W'($urandom);
            out_ready = rdy_pat[n % rdy_pat.size()];
            @(negedge clk);
            if (held && (!out_valid || out_data !== hd || out_index !== hi || out_last !== hl))
                stall_err++;
            held = out_valid && !out_ready;
            hd = out_data; hi = out_index; hl = out_last;
            if (out_valid && first_ov_cyc < 0) first_ov_cyc = n;
            ir_log.push_back(in_ready);
            inf_log.push_back(in_valid && in_ready);
            lastfire_log.push_back(out_valid && out_ready && out_last);
            if (in_valid && in_ready) begin
                void'(in_q.pop_front());
                last_in_cyc = n;
            end
            if (out_valid && out_ready) begin
                od_q.push_back(out_data);
                oi_q.push_back(int'(out_index));
                ol_q.push_back(out_last);
            end
            n++;
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
        checks++; if (out_index !== '0) begin errors++; $display("FAIL reset_out_index: got %0d expected 0", out_index); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low: got %b expected 0", in_ready); end
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_after: got %b expected 1", in_ready); end
    endtask

    task automatic test_basic();
        logic [W-1:0] f[N];
        for (int k = 0; k < N; k++) f[k] = W'(rev(k, LOG2N));
        clear_model(); push_frame(f);
        rdy_pat = {1'b1}; rand_valid = 0;
        run(100, N);
        checks++; if (timed_out) begin errors++; $display("FAIL basic_timeout: got %0d outputs expected %0d", od_q.size(), N); end
        checks++; if (od_q.size() != exp_d.size()) begin errors++; $display("FAIL basic_count: got %0d expected %0d", od_q.size(), exp_d.size()); end
        for (int j = 0; j < od_q.size() && j < exp_d.size(); j++) begin
            checks++; if (od_q[j] !== exp_d[j]) begin errors++; $display("FAIL basic_data[%0d]: got %h expected %h", j, od_q[j], exp_d[j]); end
            checks++; if (od_q[j] !== W'(j)) begin errors++; $display("FAIL basic_bin[%0d]: got %h expected %h", j, od_q[j], W'(j)); end
            checks++; if (oi_q[j] != exp_i[j]) begin errors++; $display("FAIL basic_index[%0d]: got %0d expected %0d", j, oi_q[j], exp_i[j]); end
            checks++; if (ol_q[j] != (exp_i[j] == N - 1)) begin errors++; $display("FAIL basic_last[%0d]: got %0d expected %0d", j, ol_q[j], exp_i[j] == N - 1); end
        end
        checks++; if (first_ov_cyc - last_in_cyc != 2) begin errors++; $display("FAIL basic_latency: got %0d expected 2", first_ov_cyc - last_in_cyc); end
    endtask

    task automatic test_stall();
        logic [W-1:0] f[N];
        for (int k = 0; k < N; k++) f[k] = W'(rev(k, LOG2N));
        clear_model(); push_frame(f);
        rdy_pat = {1'b1, 1'b0, 1'b0, 1'b1}; rand_valid = 0;
        run(200, N);
        checks++; if (timed_out) begin errors++; $display("FAIL stall_timeout: got %0d outputs expected %0d", od_q.size(), N); end
        checks++; if (od_q.size() != exp_d.size()) begin errors++; $display("FAIL stall_count: got %0d expected %0d", od_q.size(), exp_d.size()); end
        for (int j = 0; j < od_q.size() && j < exp_d.size(); j++) begin
            checks++; if (od_q[j] !== exp_d[j]) begin errors++; $display("FAIL stall_data[%0d]: got %h expected %h", j, od_q[j], exp_d[j]); end
            checks++; if (oi_q[j] != exp_i[j]) begin errors++; $display("FAIL stall_index[%0d]: got %0d expected %0d", j, oi_q[j], exp_i[j]); end
            checks++; if (ol_q[j] != (exp_i[j] == N - 1)) begin errors++; $display("FAIL stall_last[%0d]: got %0d expected %0d", j, ol_q[j], exp_i[j] == N - 1); end
        end
        checks++; if (stall_err != 0) begin errors++; $display("FAIL stall_hold: got %0d unstable cycles expected 0", stall_err); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] f[N];
        int           nfr;
        int           p, q, viol;
`ifdef FFT_REORDER_PINGPONG_EN
        nfr = 4;
`else
        nfr = 2;
`endif
        clear_model();
        for (int fr = 0; fr < nfr; fr++) begin
            for (int k = 0; k < N; k++) f[k] = W'($urandom);
            push_frame(f);
        end
        rdy_pat = {1'b1}; rand_valid = 0;
        run(400, nfr * N);
        checks++; if (timed_out) begin errors++; $display("FAIL b2b_timeout: got %0d outputs expected %0d", od_q.size(), nfr * N); end
        checks++; if (od_q.size() != exp_d.size()) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", od_q.size(), exp_d.size()); end
        for (int j = 0; j < od_q.size() && j < exp_d.size(); j++) begin
            checks++; if (od_q[j] !== exp_d[j]) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", j, od_q[j], exp_d[j]); end
            checks++; if (oi_q[j] != exp_i[j]) begin errors++; $display("FAIL b2b_index[%0d]: got %0d expected %0d", j, oi_q[j], exp_i[j]); end
            checks++; if (ol_q[j] != (exp_i[j] == N - 1)) begin errors++; $display("FAIL b2b_last[%0d]: got %0d expected %0d", j, ol_q[j], exp_i[j] == N - 1); end
        end
`ifdef FFT_REORDER_PINGPONG_EN
        viol = 0;
        for (int i = N; i <= last_in_cyc && i < ir_log.size(); i++) if (!ir_log[i]) viol++;
        checks++; if (viol != 0) begin errors++; $display("FAIL b2b_in_ready_drop: got %0d low cycles expected 0", viol); end
        checks++; if (last_in_cyc != nfr * N - 1) begin errors++; $display("FAIL b2b_stream: got last input cycle %0d expected %0d", last_in_cyc, nfr * N - 1); end
`else
        p = -1; q = -1; viol = 0;
        for (int i = 0, c = 0; i < inf_log.size(); i++) begin
            if (inf_log[i]) c++;
            if (inf_log[i] && c == N) p = i;
        end
        for (int i = p + 1; p >= 0 && i < lastfire_log.size(); i++) begin
            if (lastfire_log[i]) begin
                q = i;
                break;
            end
            if (ir_log[i]) viol++;
        end
        checks++; if (p < 0 || q < 0) begin errors++; $display("FAIL b2b_block_window: got write %0d last %0d expected both found", p, q); end
        checks++; if (viol != 0) begin errors++; $display("FAIL b2b_in_ready_blocked: got %0d high cycles expected 0", viol); end
`endif
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] f[N];
        clear_model();
        for (int k = 0; k < N; k++) f[k] = W'($urandom);
        push_frame(f);
        for (int k = 0; k < 5; k++) in_q.push_back(W'($urandom));
        rdy_pat = {1'b0}; rand_valid = 0;
        run(20, 0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid: got %b expected 1", out_valid); end
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_async_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rmid_in_ready: got %b expected 0", in_ready); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rmid_out_last: got %b expected 0", out_last); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clear_model();
        for (int k = 0; k < N; k++) f[k] = W'($urandom);
        push_frame(f);
        rdy_pat = {1'b1};
        run(100, N);
        checks++; if (od_q.size() != exp_d.size()) begin errors++; $display("FAIL rmid_count: got %0d expected %0d", od_q.size(), exp_d.size()); end
        for (int j = 0; j < od_q.size() && j < exp_d.size(); j++) begin
            checks++; if (od_q[j] !== exp_d[j]) begin errors++; $display("FAIL rmid_data[%0d]: got %h expected %h", j, od_q[j], exp_d[j]); end
            checks++; if (oi_q[j] != exp_i[j]) begin errors++; $display("FAIL rmid_index[%0d]: got %0d expected %0d", j, oi_q[j], exp_i[j]); end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] f[N];
        clear_model();
        for (int fr = 0; fr < 3; fr++) begin
            for (int k = 0; k < N; k++) f[k] = W'($urandom);
            f[$urandom_range(N - 1)] = 32'h8000_0000;
            f[$urandom_range(N - 1)] = 32'h7FFF_7FFF;
            push_frame(f);
        end
        rdy_pat.delete();
        for (int i = 0; i < 16; i++) rdy_pat.push_back(1'($urandom));
        rdy_pat[0] = 1'b1;
        rand_valid = 1;
        run(2000, 3 * N);
        rand_valid = 0;
        checks++; if (timed_out) begin errors++; $display("FAIL rand_timeout: got %0d outputs expected %0d", od_q.size(), 3 * N); end
        checks++; if (od_q.size() != exp_d.size()) begin errors++; $display("FAIL rand_count: got %0d expected %0d", od_q.size(), exp_d.size()); end
        for (int j = 0; j < od_q.size() && j < exp_d.size(); j++) begin
            checks++; if (od_q[j] !== exp_d[j]) begin errors++; $display("FAIL rand_data[%0d]: got %h expected %h", j, od_q[j], exp_d[j]); end
            checks++; if (oi_q[j] != exp_i[j]) begin errors++; $display("FAIL rand_index[%0d]: got %0d expected %0d", j, oi_q[j], exp_i[j]); end
            checks++; if (ol_q[j] != (exp_i[j] == N - 1)) begin errors++; $display("FAIL rand_last[%0d]: got %0d expected %0d", j, ol_q[j], exp_i[j] == N - 1); end
        end
        checks++; if (stall_err != 0) begin errors++; $display("FAIL rand_hold: got %0d unstable cycles expected 0", stall_err); end
    endtask

    initial begin
        rand_valid = 0;
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
